// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences data-memory req/ack accesses for the MEM stage, stalling the front of the pipeline and bubbling MEM/WB until the access completes or times out.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] Wdata_i,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [DATA_W-1:0] Memdata_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic access, last;
    assign access = MemRead_i | MemWrite_i;
    assign last   = cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (access ? REQ : IDLE) :
                    state == REQ  ? ((mem_ack_i || last) ? DONE : REQ) : IDLE;
    end
    // reset gating keeps the pipeline free-running while rst_i is held, even if EX/MEM still shows an access
    always_comb begin
        stall_o  = rst_i && ((state == IDLE && access) || state == REQ);
        bubble_o = stall_o;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            Memdata_o   <= '0;
            err_o       <= 1'b0;
            cnt         <= '0;
        end else if (state == IDLE && access) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= Addr_i;
            mem_wdata_o <= Wdata_i;
            cnt         <= '0;
        end else if (state == REQ) begin
            if (mem_ack_i) begin
                mem_req_o <= 1'b0;
                if (!mem_we_o) Memdata_o <= mem_rdata_i;
            end else if (last) begin
                mem_req_o <= 1'b0;
                Memdata_o <= '0;
                err_o     <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
